// File: rtl/fetch_line_ctrl.sv
// rtl/fetch_line_ctrl.sv - single-line fetch buffer refill sequencer
// Optional hit/miss counters are built only when FETCH_LINE_CTRL_PERF_EN is defined.
module fetch_line_ctrl #(
    parameter int XLEN   = 32,
    parameter int LINE_W = 128,
    parameter int OFF_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              pc_valid_i,
    input  logic              flush_i,
    input  logic              here_i,
    input  logic              will_be_here_i,
    output logic [XLEN-1:0]   line_pc_o,
    output logic              line_valid_o,
    output logic [XLEN-1:0]   prev_pc_o,
    output logic [LINE_W-1:0] line_o,
    output logic              fetch_valid_o,
    output logic              icache_req_valid_o,
    input  logic              icache_req_ready_i,
    output logic [XLEN-1:0]   icache_req_addr_o,
    input  logic              icache_resp_valid_i,
    input  logic [LINE_W-1:0] icache_resp_line_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] LINE_MASK = {{(XLEN-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    state_t            r_state;
    state_t            w_next_state;
    logic              w_req_valid;
    logic              r_kill;
    logic              r_line_valid;
    logic [XLEN-1:0]   r_line_pc;
    logic [XLEN-1:0]   r_prev_pc;
    logic [LINE_W-1:0] r_line;

    logic              w_fetch_valid;
    logic              w_miss;
    logic              w_redirect;
    logic [XLEN-1:0]   w_pc_aligned;
    logic              w_start;

    assign w_pc_aligned  = pc_i & LINE_MASK;
    assign w_fetch_valid = pc_valid_i & here_i & ~flush_i;
    assign w_miss        = pc_valid_i & ~here_i & ~flush_i;
    // A PC that is neither buffered nor the line being fetched makes the refill useless.
    assign w_redirect    = pc_valid_i & ~here_i & ~will_be_here_i;
    assign w_start       = (r_state == IDLE) & w_miss;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_req_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_miss) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                w_req_valid = 1'b1;
                if (icache_req_ready_i) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (icache_resp_valid_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_kill       <= 1'b0;
            r_line_valid <= 1'b0;
            r_line_pc    <= '0;
            r_prev_pc    <= '0;
            r_line       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_prev_pc <= w_pc_aligned;
                    end
                end
                REQ: begin
                    if (w_redirect || flush_i) begin
                        r_kill <= 1'b1;
                    end
                end
                WAIT: begin
                    if (icache_resp_valid_i) begin
                        r_kill <= 1'b0;
                        if (!r_kill && !flush_i) begin
                            r_line       <= icache_resp_line_i;
                            r_line_pc    <= r_prev_pc;
                            r_line_valid <= 1'b1;
                        end
                    end else if (w_redirect || flush_i) begin
                        r_kill <= 1'b1;
                    end
                end
                default: r_kill <= 1'b0;
            endcase
            if (flush_i) begin
                r_line_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_LINE_CTRL_PERF_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_fetch_valid && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_start && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif

    assign line_pc_o          = r_line_pc;
    assign line_valid_o       = r_line_valid;
    assign prev_pc_o          = r_prev_pc;
    assign line_o             = r_line;
    assign fetch_valid_o      = w_fetch_valid;
    assign icache_req_valid_o = w_req_valid;
    assign icache_req_addr_o  = r_prev_pc;

endmodule

// File: tb/tb_fetch_line_ctrl.sv
// tb/tb_fetch_line_ctrl.sv - directed self-checking bench for fetch_line_ctrl
// Counter checks follow FETCH_LINE_CTRL_PERF_EN.
module tb_fetch_line_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  pc_i;
    logic         pc_valid_i;
    logic         flush_i;
    logic         here_i;
    logic         will_be_here_i;
    logic [31:0]  line_pc_o;
    logic         line_valid_o;
    logic [31:0]  prev_pc_o;
    logic [127:0] line_o;
    logic         fetch_valid_o;
    logic         icache_req_valid_o;
    logic         icache_req_ready_i;
    logic [31:0]  icache_req_addr_o;
    logic         icache_resp_valid_i;
    logic [127:0] icache_resp_line_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] D_LINE = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] E_LINE = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;
    localparam logic [127:0] F_LINE = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    localparam logic [127:0] G_LINE = 128'hCAFE_BABE_DEAD_BEEF_1234_5678_9ABC_DEF0;
    localparam logic [127:0] H_LINE = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;

    fetch_line_ctrl dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .pc_i                (pc_i),
        .pc_valid_i          (pc_valid_i),
        .flush_i             (flush_i),
        .here_i              (here_i),
        .will_be_here_i      (will_be_here_i),
        .line_pc_o           (line_pc_o),
        .line_valid_o        (line_valid_o),
        .prev_pc_o           (prev_pc_o),
        .line_o              (line_o),
        .fetch_valid_o       (fetch_valid_o),
        .icache_req_valid_o  (icache_req_valid_o),
        .icache_req_ready_i  (icache_req_ready_i),
        .icache_req_addr_o   (icache_req_addr_o),
        .icache_resp_valid_i (icache_resp_valid_i),
        .icache_resp_line_i  (icache_resp_line_i),
        .hit_cnt_o           (hit_cnt_o),
        .miss_cnt_o          (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        pc_i = '0;
        pc_valid_i = 1'b0;
        flush_i = 1'b0;
        here_i = 1'b0;
        will_be_here_i = 1'b0;
        icache_req_ready_i = 1'b0;
        icache_resp_valid_i = 1'b0;
        icache_resp_line_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_line_valid", 128'(line_valid_o), 128'd0);
        chk("rst_line_pc", 128'(line_pc_o), 128'd0);
        chk("rst_prev_pc", 128'(prev_pc_o), 128'd0);
        chk("rst_line", line_o, 128'd0);
        chk("rst_req_valid", 128'(icache_req_valid_o), 128'd0);
        chk("rst_hit_cnt", 128'(hit_cnt_o), 128'd0);
        chk("rst_miss_cnt", 128'(miss_cnt_o), 128'd0);

        // Cold miss on 0x1004.
        pc_i = 32'h0000_1004; pc_valid_i = 1'b1; here_i = 1'b0; will_be_here_i = 1'b0;
        #1;
        chk("cold_fetch_valid", 128'(fetch_valid_o), 128'd0);
        tick();
        chk("cold_req_valid", 128'(icache_req_valid_o), 128'd1);
        chk("cold_req_addr", 128'(icache_req_addr_o), 128'h1000);
        pc_valid_i = 1'b0;
        icache_req_ready_i = 1'b1;
        tick();
        chk("cold_req_dropped", 128'(icache_req_valid_o), 128'd0);
        icache_req_ready_i = 1'b0;
        tick();
        chk("cold_not_yet", 128'(line_valid_o), 128'd0);
        icache_resp_valid_i = 1'b1; icache_resp_line_i = D_LINE;
        tick();
        icache_resp_valid_i = 1'b0;
        chk("cold_line_pc", 128'(line_pc_o), 128'h1000);
        chk("cold_line_valid", 128'(line_valid_o), 128'd1);
        chk("cold_line", line_o, D_LINE);

        // Hit on the buffered line.
        pc_i = 32'h0000_100C; pc_valid_i = 1'b1; here_i = 1'b1;
        #1;
        chk("hit_fetch_valid", 128'(fetch_valid_o), 128'd1);
        tick();
        chk("hit_no_req", 128'(icache_req_valid_o), 128'd0);
`ifdef FETCH_LINE_CTRL_PERF_EN
        chk("hit_cnt_one", 128'(hit_cnt_o), 128'd1);
`endif

        // Backpressured miss on 0x2000; fetch stalls on the same PC.
        pc_i = 32'h0000_2000; pc_valid_i = 1'b1; here_i = 1'b0; will_be_here_i = 1'b0;
        tick();
        will_be_here_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_valid", 128'(icache_req_valid_o), 128'd1);
            chk("bp_req_addr", 128'(icache_req_addr_o), 128'h2000);
            tick();
        end
        chk("bp_req_held4", 128'(icache_req_valid_o), 128'd1);
        icache_req_ready_i = 1'b1;
        tick();
        icache_req_ready_i = 1'b0;
        chk("bp_single_req", 128'(icache_req_valid_o), 128'd0);
        tick();
        chk("bp_still_single", 128'(icache_req_valid_o), 128'd0);
`ifdef FETCH_LINE_CTRL_PERF_EN
        chk("miss_cnt_two", 128'(miss_cnt_o), 128'd2);
`endif

        // Old line still serves hits during the refill.
        pc_i = 32'h0000_1008; here_i = 1'b1; will_be_here_i = 1'b0;
        #1;
        chk("refill_hit", 128'(fetch_valid_o), 128'd1);
        tick();

        // Redirect to 0x3000 while waiting: response must be dropped.
        pc_i = 32'h0000_3000; here_i = 1'b0; will_be_here_i = 1'b0;
        tick();
        pc_valid_i = 1'b0;
        icache_resp_valid_i = 1'b1; icache_resp_line_i = E_LINE;
        tick();
        icache_resp_valid_i = 1'b0;
        chk("kill_line_pc", 128'(line_pc_o), 128'h1000);
        chk("kill_line", line_o, D_LINE);
        chk("kill_line_valid", 128'(line_valid_o), 128'd1);
        pc_valid_i = 1'b1;
        tick();
        chk("rereq_valid", 128'(icache_req_valid_o), 128'd1);
        chk("rereq_addr", 128'(icache_req_addr_o), 128'h3000);
        pc_valid_i = 1'b0;
        icache_req_ready_i = 1'b1;
        tick();
        icache_req_ready_i = 1'b0;

        // Flush coincident with the response.
        icache_resp_valid_i = 1'b1; icache_resp_line_i = F_LINE; flush_i = 1'b1;
        tick();
        icache_resp_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_line_valid", 128'(line_valid_o), 128'd0);
        chk("flush_line", line_o, D_LINE);
        chk("flush_line_pc", 128'(line_pc_o), 128'h1000);
        chk("flush_req_valid", 128'(icache_req_valid_o), 128'd0);

        // Top-of-memory PC aligns by masking; also shows the FSM returned to IDLE.
        pc_i = 32'hFFFF_FFFC; pc_valid_i = 1'b1; here_i = 1'b0;
        tick();
        chk("top_req_valid", 128'(icache_req_valid_o), 128'd1);
        chk("top_req_addr", 128'(icache_req_addr_o), 128'hFFFF_FFF0);
        pc_valid_i = 1'b0;
        icache_req_ready_i = 1'b1;
        tick();
        icache_req_ready_i = 1'b0;
        icache_resp_valid_i = 1'b1; icache_resp_line_i = G_LINE;
        tick();
        icache_resp_valid_i = 1'b0;
        chk("top_line_pc", 128'(line_pc_o), 128'hFFFF_FFF0);
        chk("top_line", line_o, G_LINE);
        chk("top_line_valid", 128'(line_valid_o), 128'd1);

        // Stray response in IDLE is ignored.
        icache_resp_valid_i = 1'b1; icache_resp_line_i = H_LINE;
        tick();
        icache_resp_valid_i = 1'b0;
        chk("idle_resp_ignored", line_o, G_LINE);
        chk("idle_resp_no_req", 128'(icache_req_valid_o), 128'd0);

`ifdef FETCH_LINE_CTRL_PERF_EN
        // Saturation of the hit counter.
        force dut.r_hit_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_hit_cnt;
        pc_i = 32'hFFFF_FFF4; pc_valid_i = 1'b1; here_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        chk("hit_cnt_sat", 128'(hit_cnt_o), 128'hFFFF_FFFF);
`else
        chk("hit_cnt_off", 128'(hit_cnt_o), 128'd0);
        chk("miss_cnt_off", 128'(miss_cnt_o), 128'd0);
`endif

        // Reset in the middle of a refill abandons it.
        pc_i = 32'h0000_4000; pc_valid_i = 1'b1; here_i = 1'b0;
        tick();
        pc_valid_i = 1'b0;
        chk("mid_req_valid", 128'(icache_req_valid_o), 128'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_req", 128'(icache_req_valid_o), 128'd0);
        chk("mid_rst_line_valid", 128'(line_valid_o), 128'd0);
        icache_resp_valid_i = 1'b1; icache_resp_line_i = H_LINE;
        tick();
        icache_resp_valid_i = 1'b0;
        chk("mid_late_resp_valid", 128'(line_valid_o), 128'd0);
        chk("mid_late_resp_line", line_o, 128'd0);
        chk("mid_cnt_clear", 128'(hit_cnt_o), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
